// File: rtl/proc_pkg.sv
// Shared processor types: data-memory FSM states, read-output select and default word geometry.
// Default widths are common to the ALU, accumulator and data memory.
package proc_pkg;

   localparam int PROC_DATA_W = 8;
   localparam int PROC_ADDR_W = 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      RD_ZERO = 2'd0,
      RD_RAM  = 2'd1,
      RD_BYP  = 2'd2
   } rd_sel_t;

endpackage

// File: rtl/ram_sdp.sv
// Bare simple-dual-port array: one write port, one registered read port, no bypass and no reset.
// Read latency 1 cycle; rdata_o holds while re_i is low. Never stalls.
module ram_sdp #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Callers keep both addresses below DEPTH whenever the matching enable is high.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_param.sv
// Parametrised data memory with post-reset clear engine, write-first collision bypass and range check.
// Read latency 1 cycle; while busy (clear running) every request is ignored, no other backpressure.
module data_memory_param
   import proc_pkg::*;
#(
   parameter int DATA_W         = PROC_DATA_W,
   parameter int ADDR_W         = PROC_ADDR_W,
   parameter int DEPTH          = 256,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              err_oob
);

   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] clr_ptr_q;
   rd_sel_t           sel_q;
   logic [DATA_W-1:0] byp_q;
   logic              rd_valid_q;
   logic              err_oob_q;
   logic              busy_q;

   logic              run;
   logic              wr_inr;
   logic              rd_inr;
   logic              wr_acc;
   logic              rd_acc;
   logic              collide;
   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   assign run     = (state_q == RUN);
   assign wr_inr  = ({1'b0, wr_addr} < DEPTH_L);
   assign rd_inr  = ({1'b0, rd_addr} < DEPTH_L);
   assign wr_acc  = run & wr_en;
   assign rd_acc  = run & rd_en;
   assign collide = wr_acc & rd_acc & wr_inr & rd_inr & (wr_addr == rd_addr);

   // Clear engine borrows the single write port; gating with rst_n keeps reset from touching the array.
   assign ram_we    = rst_n & (run ? (wr_acc & wr_inr) : 1'b1);
   assign ram_waddr = run ? wr_addr : clr_ptr_q;
   assign ram_wdata = run ? wr_data : '0;
   assign ram_re    = rd_acc & rd_inr & ~collide;

   ram_sdp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
         busy_q     <= (CLEAR_ON_RESET != 0);
         clr_ptr_q  <= '0;
         sel_q      <= RD_ZERO;
         byp_q      <= '0;
         rd_valid_q <= 1'b0;
         err_oob_q  <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         err_oob_q  <= (wr_acc & ~wr_inr) | (rd_acc & ~rd_inr);
         if (rd_acc) begin
            if (!rd_inr) begin
               sel_q <= RD_ZERO;
            end else if (collide) begin
               sel_q <= RD_BYP;
               byp_q <= wr_data;
            end else begin
               sel_q <= RD_RAM;
            end
         end
         case (state_q)
            INIT: begin
               if (clr_ptr_q == LAST_PTR) begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
               end else begin
                  clr_ptr_q <= clr_ptr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The RAM output register is only refreshed on real reads, so every select holds while rd_en is low.
   always_comb begin
      rd_data = '0;
      case (sel_q)
         RD_RAM:  rd_data = ram_rdata;
         RD_BYP:  rd_data = byp_q;
         default: rd_data = '0;
      endcase
   end

   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
   assign err_oob  = err_oob_q;

endmodule
